// File: rtl/name_table_fetcher.sv
// Fetches one 32-tile name-table row per scanline and streams tile indices (1 byte per tile) over valid/ready.
// Coarse horizontal scroll wraps at 32 tiles; each new word costs an ADDR/WAIT/LATCH bubble.
module name_table_fetcher #(
    parameter int ADDR_W = 8,
    parameter int ROWS   = 30,
    parameter int COLS   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              line_start_i,
    input  logic [7:0]        line_y_i,
    input  logic [4:0]        scroll_x_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [31:0]       ram_rdata_i,
    output logic              tile_valid_o,
    input  logic              tile_ready_i,
    output logic [7:0]        tile_idx_o,
    output logic [4:0]        tile_col_o,
    output logic              tile_last_o,
    output logic              busy_o,
    output logic              line_done_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WAIT  = 3'd2,
        LATCH = 3'd3,
        EMIT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [4:0] LAST_K  = 5'(COLS - 1);
    localparam logic [8:0] Y_LIMIT = 9'(ROWS * 8);

    state_t            state_q;
    logic [4:0]        row_q;
    logic [4:0]        sx_q;
    logic [4:0]        k_q;
    logic [31:0]       word_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              tile_valid_q;
    logic [7:0]        tile_idx_q;
    logic [4:0]        tile_col_q;
    logic              tile_last_q;
    logic              busy_q;
    logic              line_done_q;

    logic [4:0] col_cur;
    logic [4:0] k_d;
    logic [4:0] col_d;

    // Column arithmetic is 5 bits wide so scroll wraps at 32 tiles for free.
    assign col_cur = sx_q + k_q;
    assign k_d     = k_q + 5'd1;
    assign col_d   = sx_q + k_d;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] sel);
        case (sel)
            2'd0:    byte_sel = w[7:0];
            2'd1:    byte_sel = w[15:8];
            2'd2:    byte_sel = w[23:16];
            default: byte_sel = w[31:24];
        endcase
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            row_q        <= '0;
            sx_q         <= '0;
            k_q          <= '0;
            word_q       <= '0;
            ram_addr_q   <= '0;
            tile_valid_q <= 1'b0;
            tile_idx_q   <= '0;
            tile_col_q   <= '0;
            tile_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            line_done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (line_start_i && ({1'b0, line_y_i} < Y_LIMIT)) begin
                        row_q   <= line_y_i[7:3];
                        sx_q    <= scroll_x_i;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    ram_addr_q <= ADDR_W'({row_q, col_cur[4:2]});
                    state_q    <= WAIT;
                end
                WAIT: begin
                    state_q <= LATCH;
                end
                LATCH: begin
                    word_q       <= ram_rdata_i;
                    tile_idx_q   <= byte_sel(ram_rdata_i, col_cur[1:0]);
                    tile_col_q   <= k_q;
                    tile_last_q  <= (k_q == LAST_K);
                    tile_valid_q <= 1'b1;
                    state_q      <= EMIT;
                end
                EMIT: begin
                    if (tile_ready_i) begin
                        if (k_q == LAST_K) begin
                            tile_valid_q <= 1'b0;
                            tile_last_q  <= 1'b0;
                            line_done_q  <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            k_q <= k_d;
                            if (col_d[1:0] == 2'd0) begin
                                tile_valid_q <= 1'b0;
                                state_q      <= ADDR;
                            end else begin
                                tile_idx_q  <= byte_sel(word_q, col_d[1:0]);
                                tile_col_q  <= k_d;
                                tile_last_q <= (k_d == LAST_K);
                            end
                        end
                    end
                end
                DONE: begin
                    line_done_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_addr_o   = ram_addr_q;
    assign tile_valid_o = tile_valid_q;
    assign tile_idx_o   = tile_idx_q;
    assign tile_col_o   = tile_col_q;
    assign tile_last_o  = tile_last_q;
    assign busy_o       = busy_q;
    assign line_done_o  = line_done_q;

endmodule

// File: tb/tb_name_table_fetcher.sv
// Directed bench for name_table_fetcher with a 1-cycle registered RAM model.
module tb_name_table_fetcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        line_start;
    logic [7:0]  line_y;
    logic [4:0]  scroll_x;
    logic [7:0]  ram_addr;
    logic [31:0] ram_rdata;
    logic        tile_valid;
    logic        tile_ready;
    logic [7:0]  tile_idx;
    logic [4:0]  tile_col;
    logic        tile_last;
    logic        busy;
    logic        line_done;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem [256];
    logic [31:0] ram_q;

    always #5 clk = ~clk;

    always_ff @(posedge clk) ram_q <= mem[ram_addr];
    assign ram_rdata = ram_q;

    name_table_fetcher #(.ADDR_W(8), .ROWS(30), .COLS(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .line_start_i (line_start),
        .line_y_i     (line_y),
        .scroll_x_i   (scroll_x),
        .ram_addr_o   (ram_addr),
        .ram_rdata_i  (ram_rdata),
        .tile_valid_o (tile_valid),
        .tile_ready_i (tile_ready),
        .tile_idx_o   (tile_idx),
        .tile_col_o   (tile_col),
        .tile_last_o  (tile_last),
        .busy_o       (busy),
        .line_done_o  (line_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Streams one line and checks every tile; optional stall, colliding start, or mid-line reset.
    task automatic run_line(input logic [7:0] y, input logic [4:0] sx, input int stall_k,
                            input int collide_k, input int rst_k, input int exp_fetch);
        int k = 0;
        int cyc = 1;
        int first_cyc = -1;
        int fetches = 0;
        int stall_cnt = 0;
        logic prev_vld = 1'b0;
        logic last_xfer = 1'b0;
        logic done_ok = 1'b0;
        logic collided = 1'b0;
        int row = int'(y) >> 3;
        int col;

        @(negedge clk);
        line_y = y; scroll_x = sx; line_start = 1'b1; tile_ready = 1'b1;
        @(negedge clk);
        while (cyc < 400) begin
            line_start = 1'b0;
            if (last_xfer) begin
                chk("line_done_pulse", 32'(line_done), 32'd1);
                chk("busy_in_done", 32'(busy), 32'd1);
                done_ok = 1'b1;
                break;
            end
            chk("line_done_early", 32'(line_done), 32'd0);
            chk("busy_active", 32'(busy), 32'd1);
            tile_ready = 1'b1;
            if (tile_valid) begin
                if (!prev_vld) begin
                    fetches++;
                    if (first_cyc < 0) first_cyc = cyc;
                end
                col = (int'(sx) + k) % 32;
                chk("tile_col", 32'(tile_col), 32'(k));
                chk("tile_idx", 32'(tile_idx), 32'((row * 32 + col) % 256));
                chk("tile_last", 32'(tile_last), 32'(k == 31));
                chk("ram_addr", 32'(ram_addr), 32'(row * 8 + col / 4));
                if (k == rst_k) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk("rst_valid", 32'(tile_valid), 32'd0);
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_done", 32'(line_done), 32'd0);
                    chk("rst_addr", 32'(ram_addr), 32'd0);
                    chk("rst_last", 32'(tile_last), 32'd0);
                    for (int i = 0; i < 8; i++) begin
                        @(negedge clk);
                        chk("post_rst_valid", 32'(tile_valid), 32'd0);
                        chk("post_rst_done", 32'(line_done), 32'd0);
                    end
                    return;
                end
                if (k == stall_k && stall_cnt < 5) begin
                    tile_ready = 1'b0;
                    stall_cnt++;
                end
                if (k == collide_k && !collided) begin
                    line_y = 8'd16; scroll_x = 5'd5; line_start = 1'b1;
                    collided = 1'b1;
                end
                if (tile_ready) begin
                    if (k == 31) last_xfer = 1'b1;
                    k++;
                end
            end
            prev_vld = tile_valid;
            @(negedge clk);
            cyc++;
        end
        chk("line_completed", 32'(done_ok), 32'd1);
        chk("first_valid_latency", 32'(first_cyc), 32'd4);
        chk("fetch_count", 32'(fetches), 32'(exp_fetch));
        if (stall_k >= 0) chk("stall_cycles", 32'(stall_cnt), 32'd5);
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_single_pulse", 32'(line_done), 32'd0);
    endtask

    initial begin
        for (int n = 0; n < 256; n++) begin
            mem[n] = {8'(4*n + 3), 8'(4*n + 2), 8'(4*n + 1), 8'(4*n)};
        end
        rst = 1'b1; line_start = 1'b0; line_y = '0; scroll_x = '0; tile_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_addr", 32'(ram_addr), 32'd0);
        chk("reset_valid", 32'(tile_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(line_done), 32'd0);
        chk("reset_last", 32'(tile_last), 32'd0);
        chk("reset_idx", 32'(tile_idx), 32'd0);
        chk("reset_col", 32'(tile_col), 32'd0);

        run_line(8'd0, 5'd0, -1, -1, -1, 8);
        run_line(8'd237, 5'd0, -1, -1, -1, 8);

        line_y = 8'd240; scroll_x = 5'd0; line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("y240_busy", 32'(busy), 32'd0);
            chk("y240_valid", 32'(tile_valid), 32'd0);
            @(negedge clk);
        end

        run_line(8'd8, 5'd30, -1, -1, -1, 9);
        run_line(8'd16, 5'd0, 2, -1, -1, 8);
        run_line(8'd24, 5'd1, -1, 10, -1, 9);
        run_line(8'd40, 5'd3, -1, -1, 17, 9);
        run_line(8'd48, 5'd6, -1, -1, -1, 9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
